// File: rtl/uart_fifo.sv
// Buffered 8N1 UART peripheral: memory-mapped register block, TX/RX FIFOs
// and baud-divided serial engines sharing one sysclk domain.

module uart_fifo_buf #(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic        sysclk,
    input  logic        reset,
    input  logic        push,
    input  logic [7:0]  push_data,
    input  logic        pop,
    output logic [7:0]  head,
    output logic [AW:0] count,
    output logic        empty,
    output logic        full
);
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    // A pop on empty is ignored; a push on full lands only when a pop frees the slot.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign head    = mem[rd_ptr];

    // NOTE: storage is not reset; pointers and count define validity, so stale entries are never visible.
    always_ff @(posedge sysclk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end
endmodule

module uart_fifo #(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD       = 9600,
    parameter int FIFO_DEPTH = 16
) (
    input  logic        sysclk,
    input  logic        reset,
    input  logic        um_rd,
    input  logic        um_wr,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] um_data,
    input  logic        uart_rx,
    output logic        uart_tx,
    output logic        irq
);
    localparam int DIV  = CLK_FREQ / BAUD;
    localparam int HALF = DIV / 2;
    localparam int CW   = $clog2(DIV);
    localparam int AW   = $clog2(FIFO_DEPTH);

    localparam logic [CW-1:0] BIT_END  = CW'(DIV - 1);
    localparam logic [CW-1:0] HALF_END = CW'(HALF - 1);

    localparam logic [7:0] A_TXDATA = 8'h18;
    localparam logic [7:0] A_RXDATA = 8'h1c;
    localparam logic [7:0] A_STATUS = 8'h20;
    localparam logic [7:0] A_CTRL   = 8'h24;

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} line_state_t;

    logic [7:0] reg_addr;
    logic       tx_push, rx_pop, status_wr, ctrl_wr;

    assign reg_addr  = addr[7:0];
    assign tx_push   = um_wr & (reg_addr == A_TXDATA);
    assign rx_pop    = um_rd & (reg_addr == A_RXDATA);
    assign status_wr = um_wr & (reg_addr == A_STATUS);
    assign ctrl_wr   = um_wr & (reg_addr == A_CTRL);

    logic unused_bus;
    assign unused_bus = ^{addr[31:8], wdata[31:8]};

    logic [7:0]  tx_head, rx_head, rx_shift;
    logic [AW:0] tx_count, rx_count;
    logic        tx_empty, tx_full, rx_empty, rx_full;
    logic        tx_pop, rx_push;

    uart_fifo_buf #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .sysclk    (sysclk),
        .reset     (reset),
        .push      (tx_push),
        .push_data (wdata[7:0]),
        .pop       (tx_pop),
        .head      (tx_head),
        .count     (tx_count),
        .empty     (tx_empty),
        .full      (tx_full)
    );

    uart_fifo_buf #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .sysclk    (sysclk),
        .reset     (reset),
        .push      (rx_push),
        .push_data (rx_shift),
        .pop       (rx_pop),
        .head      (rx_head),
        .count     (rx_count),
        .empty     (rx_empty),
        .full      (rx_full)
    );

    // ---------------- transmit engine ----------------
    line_state_t   tx_state, tx_state_d;
    logic [CW-1:0] tx_cnt, tx_cnt_d;
    logic [2:0]    tx_bit, tx_bit_d;
    logic [7:0]    tx_shift, tx_shift_d;
    logic          tx_line_d, tx_tick, tx_busy;

    assign tx_tick = (tx_cnt == BIT_END);
    assign tx_busy = (tx_state != S_IDLE) | ~tx_empty;

    always_comb begin
        // NOTE: every combinational output gets a default first, so no path can infer a latch.
        tx_state_d = tx_state;
        tx_cnt_d   = tx_cnt;
        tx_bit_d   = tx_bit;
        tx_shift_d = tx_shift;
        tx_line_d  = uart_tx;
        tx_pop     = 1'b0;
        unique case (tx_state)
            S_IDLE: begin
                tx_line_d = 1'b1;
                if (!tx_empty) begin
                    tx_pop     = 1'b1;
                    tx_shift_d = tx_head;
                    tx_cnt_d   = '0;
                    tx_line_d  = 1'b0;
                    tx_state_d = S_START;
                end
            end
            S_START: begin
                if (tx_tick) begin
                    tx_cnt_d   = '0;
                    tx_bit_d   = '0;
                    tx_line_d  = tx_shift[0];
                    tx_state_d = S_DATA;
                end else begin
                    tx_cnt_d = tx_cnt + 1'b1;
                end
            end
            S_DATA: begin
                if (tx_tick) begin
                    tx_cnt_d = '0;
                    if (tx_bit == 3'd7) begin
                        tx_line_d  = 1'b1;
                        tx_state_d = S_STOP;
                    end else begin
                        tx_bit_d   = tx_bit + 1'b1;
                        tx_shift_d = {1'b0, tx_shift[7:1]};
                        tx_line_d  = tx_shift[1];
                    end
                end else begin
                    tx_cnt_d = tx_cnt + 1'b1;
                end
            end
            S_STOP: begin
                if (tx_tick) begin
                    tx_cnt_d = '0;
                    // Chain straight into the next start bit so queued frames leave no gap.
                    if (!tx_empty) begin
                        tx_pop     = 1'b1;
                        tx_shift_d = tx_head;
                        tx_line_d  = 1'b0;
                        tx_state_d = S_START;
                    end else begin
                        tx_line_d  = 1'b1;
                        tx_state_d = S_IDLE;
                    end
                end else begin
                    tx_cnt_d = tx_cnt + 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            tx_state <= S_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
            uart_tx  <= 1'b1;
        end else begin
            tx_state <= tx_state_d;
            tx_cnt   <= tx_cnt_d;
            tx_bit   <= tx_bit_d;
            tx_shift <= tx_shift_d;
            uart_tx  <= tx_line_d;
        end
    end

    // ---------------- receive engine ----------------
    logic          rx_meta, rx_sync, rx_prev, rx_fall;
    line_state_t   rx_state, rx_state_d;
    logic [CW-1:0] rx_cnt, rx_cnt_d;
    logic [2:0]    rx_bit, rx_bit_d;
    logic [7:0]    rx_shift_d;
    logic          ferr_set;

    assign rx_fall = rx_prev & ~rx_sync;

    always_comb begin
        rx_state_d = rx_state;
        rx_cnt_d   = rx_cnt;
        rx_bit_d   = rx_bit;
        rx_shift_d = rx_shift;
        rx_push    = 1'b0;
        ferr_set   = 1'b0;
        unique case (rx_state)
            S_IDLE: begin
                if (rx_fall) begin
                    rx_cnt_d   = '0;
                    rx_state_d = S_START;
                end
            end
            S_START: begin
                if (rx_cnt == HALF_END) begin
                    rx_cnt_d   = '0;
                    rx_bit_d   = '0;
                    rx_state_d = rx_sync ? S_IDLE : S_DATA;
                end else begin
                    rx_cnt_d = rx_cnt + 1'b1;
                end
            end
            S_DATA: begin
                if (rx_cnt == BIT_END) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rx_sync, rx_shift[7:1]};
                    if (rx_bit == 3'd7) rx_state_d = S_STOP;
                    else                rx_bit_d   = rx_bit + 1'b1;
                end else begin
                    rx_cnt_d = rx_cnt + 1'b1;
                end
            end
            S_STOP: begin
                if (rx_cnt == BIT_END) begin
                    rx_cnt_d   = '0;
                    rx_state_d = S_IDLE;
                    rx_push    = rx_sync;
                    ferr_set   = ~rx_sync;
                end else begin
                    rx_cnt_d = rx_cnt + 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            rx_meta  <= 1'b1;
            rx_sync  <= 1'b1;
            rx_prev  <= 1'b1;
            rx_state <= S_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
        end else begin
            rx_meta  <= uart_rx;
            rx_sync  <= rx_meta;
            rx_prev  <= rx_sync;
            rx_state <= rx_state_d;
            rx_cnt   <= rx_cnt_d;
            rx_bit   <= rx_bit_d;
            rx_shift <= rx_shift_d;
        end
    end

    // ---------------- control, flags and interrupt ----------------
    logic [2:0]  ctrl;
    logic        ovr, ferr, txovf;
    logic        ovr_set, txovf_set;
    logic [31:0] status;

    // A full RX FIFO still accepts the byte when a bus read pops on the same edge.
    assign ovr_set   = rx_push & rx_full & ~rx_pop;
    assign txovf_set = tx_push & tx_full & ~tx_pop;

    assign status = {8'h00, 8'(tx_count), 8'(rx_count),
                     txovf, ferr, ovr, rx_full, ~rx_empty, tx_busy, tx_empty, tx_full};

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            ctrl  <= '0;
            ovr   <= 1'b0;
            ferr  <= 1'b0;
            txovf <= 1'b0;
            irq   <= 1'b0;
        end else begin
            if (ctrl_wr) ctrl <= wdata[2:0];
            ovr   <= ovr_set   | (ovr   & ~(status_wr & wdata[5]));
            ferr  <= ferr_set  | (ferr  & ~(status_wr & wdata[6]));
            txovf <= txovf_set | (txovf & ~(status_wr & wdata[7]));
            irq   <= (ctrl[0] & ~rx_empty) | (ctrl[1] & ~tx_busy) |
                     (ctrl[2] & (ovr | ferr | txovf));
        end
    end

    always_comb begin
        um_data = '0;
        if (um_rd) begin
            case (reg_addr)
                A_RXDATA: um_data = {24'h0, rx_empty ? 8'h00 : rx_head};
                A_STATUS: um_data = status;
                A_CTRL:   um_data = {29'h0, ctrl};
                default:  ;
            endcase
        end
    end
endmodule
